// File: rtl/ss_entrada.sv
// ss_entrada: input subsystem of the Booth multiplier.
// Collects two operands over a shared data bus, one per rising edge of
// `load`, then pulses `start` to the Booth core and blocks further input
// until the core returns `done`.
// Optional macro SS_ENTRADA_SYNC_EN: passes `load` through a two-flop
// synchronizer and delays `data_in` by the same two stages so that both
// stay aligned. This adds two cycles of capture latency.
module ss_entrada #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             done,
  output logic [WIDTH-1:0] mult_a,
  output logic [WIDTH-1:0] mult_b,
  output logic             start,
  output logic             busy,
  output logic             sel
);

  typedef enum logic [1:0] {
    IDLE_A = 2'd0,
    WAIT_B = 2'd1,
    START  = 2'd2,
    BUSY   = 2'd3
  } state_t;

  state_t           state;
  logic             load_s;
  logic [WIDTH-1:0] data_s;
  logic             load_q;
  logic             load_rise;

`ifdef SS_ENTRADA_SYNC_EN
  logic             load_p0;
  logic             load_p1;
  logic [WIDTH-1:0] data_p0;
  logic [WIDTH-1:0] data_p1;

  // Two-flop synchronizer for the asynchronous strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_p0 <= 1'b0;
      load_p1 <= 1'b0;
    end else begin
      load_p0 <= load;
      load_p1 <= load_p0;
    end
  end

  // Matching two-stage delay keeps the operand aligned with its strobe.
  always_ff @(posedge clk) begin
    data_p0 <= data_in;
    data_p1 <= data_p0;
  end

  assign load_s = load_p1;
  assign data_s = data_p1;
`else
  assign load_s = load;
  assign data_s = data_in;
`endif

  // Previous-cycle strobe for edge detection; reset to 0 so a strobe held
  // high across reset release counts as a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) load_q <= 1'b0;
    else     load_q <= load_s;
  end

  assign load_rise = load_s & ~load_q;

  // Operand-collection FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE_A;
      mult_a <= '0;
      mult_b <= '0;
      start  <= 1'b0;
      busy   <= 1'b0;
      sel    <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        IDLE_A: begin
          if (load_rise) begin
            mult_a <= data_s;
            sel    <= 1'b1;
            state  <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (load_rise) begin
            mult_b <= data_s;
            sel    <= 1'b0;
            state  <= START;
          end
        end
        START: begin
          // Operands are complete; issue the single start pulse.
          start <= 1'b1;
          busy  <= 1'b1;
          state <= BUSY;
        end
        BUSY: begin
          // Strobes are dropped here; only done releases the block.
          if (done) begin
            busy  <= 1'b0;
            state <= IDLE_A;
          end
        end
        default: begin
          state <= IDLE_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ss_entrada.sv
// Directed testbench for ss_entrada. Works with or without
// SS_ENTRADA_SYNC_EN; LAT accounts for the synchronizer delay.
module tb_ss_entrada;

`ifdef SS_ENTRADA_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] data_in;
  logic       load;
  logic       done;
  logic [3:0] mult_a;
  logic [3:0] mult_b;
  logic       start;
  logic       busy;
  logic       sel;

  int checks;
  int failures;

  ss_entrada #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .load    (load),
    .done    (done),
    .mult_a  (mult_a),
    .mult_b  (mult_b),
    .start   (start),
    .busy    (busy),
    .sel     (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle load pulse; returns just after the capture edge.
  task automatic pulse(input logic [3:0] d);
    data_in = d;
    load    = 1'b1;
    tick();
    load    = 1'b0;
    repeat (LAT) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"},     mult_a, 0);
    chk({tag, "_b"},     mult_b, 0);
    chk({tag, "_start"}, start,  0);
    chk({tag, "_busy"},  busy,   0);
    chk({tag, "_sel"},   sel,    0);
  endtask

  initial begin
    int starts;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    data_in  = 4'h0;
    load     = 1'b0;
    done     = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_all_zero("reset");

    // Basic sequence: A=3, B=B.
    pulse(4'h3);
    chk("seq_a", mult_a, 4'h3);
    chk("seq_sel_wait_b", sel, 1);
    tick();
    pulse(4'hB);
    chk("seq_b", mult_b, 4'hB);
    chk("seq_sel_after_b", sel, 0);
    chk("seq_start_not_yet", start, 0);
    chk("seq_busy_not_yet", busy, 0);
    tick();
    chk("seq_start", start, 1);
    chk("seq_busy", busy, 1);
    tick();
    chk("seq_start_one_cycle", start, 0);
    chk("seq_busy_hold", busy, 1);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("seq_done_busy", busy, 0);
    chk("seq_done_sel", sel, 0);

    // Held strobe: one capture only, never a start.
    data_in = 4'h5;
    load    = 1'b1;
    starts  = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (start) starts++;
    end
    load = 1'b0;
    repeat (LAT + 2) begin
      tick();
      if (start) starts++;
    end
    chk("held_a", mult_a, 4'h5);
    chk("held_sel", sel, 1);
    chk("held_no_start", starts, 0);

    // Blocked input during BUSY.
    pulse(4'h7);
    chk("blk_b", mult_b, 4'h7);
    tick();
    tick();
    chk("blk_busy", busy, 1);
    pulse(4'hF);
    tick();
    chk("blk_a_kept", mult_a, 4'h5);
    chk("blk_b_kept", mult_b, 4'h7);
    chk("blk_sel", sel, 0);
    chk("blk_busy_still", busy, 1);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("blk_done_busy", busy, 0);
    chk("blk_done_sel", sel, 0);
    pulse(4'h9);
    chk("blk_next_a", mult_a, 4'h9);
    chk("blk_next_sel", sel, 1);

    // Spurious done in WAIT_B.
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk("spur_wb_sel", sel, 1);
    chk("spur_wb_a", mult_a, 4'h9);
    chk("spur_wb_busy", busy, 0);

    // Reset in WAIT_B.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("rst_wb");

    // Spurious done in IDLE_A, then a full pair proves IDLE_A was kept.
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("spur_idle_sel", sel, 0);
    chk("spur_idle_busy", busy, 0);
    pulse(4'h2);
    chk("spur_idle_a", mult_a, 4'h2);
    chk("spur_idle_sel2", sel, 1);
    tick();
    pulse(4'h4);
    chk("pair2_b", mult_b, 4'h4);
    tick();
    chk("pair2_start", start, 1);
    tick();
    chk("pair2_busy", busy, 1);

    // Reset in BUSY.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("rst_busy");

    // done and load rise in the same BUSY cycle: the rise is dropped.
    pulse(4'h1);
    tick();
    pulse(4'h8);
    tick();
    tick();
    chk("coinc_busy", busy, 1);
    data_in = 4'hE;
    load    = 1'b1;
    repeat (LAT) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    load = 1'b0;
    repeat (LAT + 1) tick();
    chk("coinc_busy_fall", busy, 0);
    chk("coinc_sel", sel, 0);
    chk("coinc_a_kept", mult_a, 4'h1);
    chk("coinc_b_kept", mult_b, 4'h8);

    // load held high across reset release is a fresh edge.
    data_in = 4'h6;
    load    = 1'b1;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("rst_load");
    tick();
    repeat (LAT) tick();
    load = 1'b0;
    chk("rst_load_a", mult_a, 4'h6);
    chk("rst_load_sel", sel, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
